// File: rtl/lc3b_fetch_queue.sv
// LC-3b instruction prefetch queue feeding the decode latch, with branch/trap redirect.
// Optional build macro LC3B_FETCH_BYPASS_EN: an empty queue forwards the fetched word straight into decode.
module lc3b_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dep_stall,
  input  logic          mem_stall,
  input  logic          v_de_br_stall,
  input  logic          v_agex_br_stall,
  input  logic          v_mem_br_stall,
  input  logic [1:0]    mem_pcmux,
  input  logic [15:0]   target_pc,
  input  logic [15:0]   trap_pc,
  output logic [15:0]   imem_addr,
  output logic          imem_req,
  input  logic [15:0]   imem_rdata,
  input  logic          imem_r,
  output logic [15:0]   pc,
  output logic [15:0]   de_npc,
  output logic [15:0]   de_ir,
  output logic          de_v,
  output logic [CW-1:0] q_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   q_npc [DEPTH];
  logic [15:0]   q_ir  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  logic        redirect, full, empty, push, pop, enq, bypass, ld_de, br_any;
  logic [15:0] redirect_pc, pc_inc;

  assign redirect    = ((mem_pcmux == 2'b01) || (mem_pcmux == 2'b10)) && !mem_stall;
  assign redirect_pc = (mem_pcmux == 2'b10) ? trap_pc : target_pc;
  assign full        = (q_count == CW'(DEPTH));
  assign empty       = (q_count == '0);
  assign ld_de       = !dep_stall && !mem_stall;
  assign br_any      = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
  assign pc_inc      = pc + 16'd2;

  assign imem_req  = !full && !redirect;
  assign imem_addr = pc;
  assign push      = imem_req && imem_r;
  assign pop       = ld_de && !br_any && !empty && !redirect;

`ifdef LC3B_FETCH_BYPASS_EN
  // Only an empty queue can bypass, so FIFO order is never violated.
  assign bypass = push && empty && ld_de && !br_any;
`else
  assign bypass = 1'b0;
`endif

  assign enq = push && !bypass;

  always_ff @(posedge clk) begin
    if (enq) begin
      q_npc[wr_ptr] <= pc_inc;
      q_ir[wr_ptr]  <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
      de_v    <= 1'b0;
      de_npc  <= '0;
      de_ir   <= '0;
    end else if (redirect) begin
      pc      <= redirect_pc;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
      if (!dep_stall) de_v <= 1'b0;
    end else begin
      if (push) pc <= pc_inc;
      if (enq)  wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({enq, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
      if (ld_de) begin
        if (pop) begin
          de_npc <= q_npc[rd_ptr];
          de_ir  <= q_ir[rd_ptr];
          de_v   <= 1'b1;
        end else if (bypass) begin
          de_npc <= pc_inc;
          de_ir  <= imem_rdata;
          de_v   <= 1'b1;
        end else begin
          de_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3b_fetch_queue.sv
// Randomized and directed bench for lc3b_fetch_queue against a queue-based reference model.
module tb_lc3b_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

`ifdef LC3B_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dep_stall = 0, mem_stall = 0;
  logic          v_de_br_stall = 0, v_agex_br_stall = 0, v_mem_br_stall = 0;
  logic [1:0]    mem_pcmux = 0;
  logic [15:0]   target_pc = 0, trap_pc = 0, imem_rdata = 0;
  logic          imem_r = 0;
  logic [15:0]   imem_addr, pc, de_npc, de_ir;
  logic          imem_req, de_v;
  logic [CW-1:0] q_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [15:0] m_pc, m_npc, m_ir;
  logic        m_v;

  lc3b_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h3000), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .dep_stall(dep_stall), .mem_stall(mem_stall),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall), .v_mem_br_stall(v_mem_br_stall),
    .mem_pcmux(mem_pcmux), .target_pc(target_pc), .trap_pc(trap_pc),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_r(imem_r),
    .pc(pc), .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc  = 16'h3000;
    m_npc = 16'h0;
    m_ir  = 16'h0;
    m_v   = 1'b0;
  endtask

  task automatic check_state();
    check_val("pc", 32'(pc), 32'(m_pc));
    check_val("q_count", 32'(q_count), 32'(mq.size()));
    check_val("de_v", 32'(de_v), 32'(m_v));
    check_val("de_npc", 32'(de_npc), 32'(m_npc));
    check_val("de_ir", 32'(de_ir), 32'(m_ir));
  endtask

  // One clock: drive inputs, check fetch outputs, advance model and DUT, check registered state.
  task automatic step(input logic r, input logic [15:0] rd, input logic dep, input logic ms,
                      input logic [2:0] br, input logic [1:0] mux,
                      input logic [15:0] tgt, input logic [15:0] trp);
    bit redirect, req, push, ld, brk, byp;
    logic [31:0] e;
    imem_r = r; imem_rdata = rd; dep_stall = dep; mem_stall = ms;
    {v_de_br_stall, v_agex_br_stall, v_mem_br_stall} = br;
    mem_pcmux = mux; target_pc = tgt; trap_pc = trp;
    #1;
    redirect = (mux == 2'd1 || mux == 2'd2) && !ms;
    req  = (mq.size() < DEPTH) && !redirect;
    push = req && r;
    ld   = !dep && !ms;
    brk  = |br;
    check_val("imem_req", 32'(imem_req), 32'(req));
    check_val("imem_addr", 32'(imem_addr), 32'(m_pc));
    if (redirect) begin
      m_pc = (mux == 2'd2) ? trp : tgt;
      mq.delete();
      if (!dep) m_v = 1'b0;
    end else begin
      byp = BYP && mq.size() == 0 && push && ld && !brk;
      if (ld) begin
        if (!brk && mq.size() > 0) begin
          e = mq.pop_front();
          m_npc = e[31:16]; m_ir = e[15:0]; m_v = 1'b1;
        end else if (byp) begin
          m_npc = m_pc + 16'd2; m_ir = rd; m_v = 1'b1;
        end else m_v = 1'b0;
      end
      if (push && !byp) mq.push_back({16'(m_pc + 16'd2), rd});
      if (push) m_pc = m_pc + 16'd2;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic run_plain(input int n, input logic r, input logic dep);
    for (int i = 0; i < n; i++) step(r, 16'(16'hA000 + i), dep, 1'b0, 3'b0, 2'd0, 16'h0, 16'h0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 check_state();
    check_val("rst_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // continuous fetch, no stalls
    run_plain(8, 1'b1, 1'b0);
    check_val("steady_de_v", 32'(de_v), 32'd1);

    // fill with decode stalled, then drain
    run_plain(8, 1'b1, 1'b1);
    check_val("full_count", 32'(q_count), 32'd4);
    check_val("full_req", 32'(imem_req), 32'd0);
    run_plain(6, 1'b0, 1'b0);

    // three entries queued, branch in flight, then redirect to 4000
    run_plain(3, 1'b1, 1'b1);
    step(1'b1, 16'h1111, 1'b0, 1'b0, 3'b001, 2'd0, 16'h0, 16'h0);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 3'b001, 2'd1, 16'h4000, 16'h0);
    check_val("redir_pc", 32'(pc), 32'h4000);
    check_val("redir_cnt", 32'(q_count), 32'd0);
    run_plain(4, 1'b1, 1'b0);

    // trap redirect held off by mem_stall
    run_plain(3, 1'b1, 1'b1);
    step(1'b1, 16'h3333, 1'b0, 1'b1, 3'b0, 2'd2, 16'h0, 16'h0200);
    step(1'b1, 16'h3334, 1'b0, 1'b1, 3'b0, 2'd2, 16'h0, 16'h0200);
    step(1'b0, 16'h3335, 1'b0, 1'b0, 3'b0, 2'd2, 16'h0, 16'h0200);
    check_val("trap_pc", 32'(pc), 32'h0200);

    // PC wrap
    step(1'b0, 16'h0, 1'b0, 1'b0, 3'b0, 2'd1, 16'hFFFE, 16'h0);
    run_plain(4, 1'b1, 1'b0);

    // async reset between edges with work in flight
    run_plain(3, 1'b1, 1'b1);
    run_plain(1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_state();
    #2 rst = 1'b0;
    step(1'b1, 16'h5555, 1'b0, 1'b0, 3'b0, 2'd0, 16'h0, 16'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  mux;
      logic [15:0] tgt;
      mux = ($urandom_range(0, 99) < 6) ? 2'($urandom_range(1, 3)) : 2'd0;
      tgt = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom) & 16'hFFFE;
      step($urandom_range(0, 99) < 70, 16'($urandom),
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
           3'(($urandom_range(0, 99) < 20) ? $urandom_range(1, 7) : 0),
           mux, tgt, 16'($urandom) & 16'hFFFE);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_state();
        #2 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
